// File: rtl/f_loader_pkg.sv
// Shared sizing and FSM encoding for the f_loader frame loader.
package f_loader_pkg;
  localparam int ROWS   = 10;
  localparam int COLS   = 3;
  localparam int WIDTH  = 64;
  localparam int N      = ROWS * COLS + 1;
  localparam int FLAT_W = ROWS * COLS * WIDTH;
  localparam int IDX_W  = $clog2(N);

  typedef enum logic [1:0] {
    LOAD   = 2'b00,
    LAUNCH = 2'b01,
    WAIT   = 2'b10
  } state_e;
endpackage

// File: rtl/f_loader_ctrl.sv
// Frame-sequencing FSM: word index, launch/busy/error pulses, commit strobe.
module f_loader_ctrl
  import f_loader_pkg::*;
#(
  parameter int FRAME_LEN = f_loader_pkg::N
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_last,
  input  logic                         done,
  output logic                         in_ready,
  output logic                         accept,
  output logic                         commit,
  output logic [$clog2(FRAME_LEN)-1:0] idx,
  output logic                         start,
  output logic                         busy,
  output logic                         err
);
  localparam int CNT_W = $clog2(FRAME_LEN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             at_end;

  // Ready is gated by rst so no word can slip in while reset is held.
  assign in_ready = (state_q == LOAD) && !rst;
  assign accept   = in_valid && in_ready;
  assign at_end   = (idx_q == CNT_W'(FRAME_LEN - 1));
  assign commit   = accept && at_end && in_last;

  always_comb begin
    // NOTE: every _d gets a default first so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    start_d = 1'b0;
    busy_d  = busy_q;
    err_d   = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          if (in_last || at_end) begin
            idx_d = '0;
            if (commit) begin
              state_d = LAUNCH;
              start_d = 1'b1;
              busy_d  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (done) begin
          state_d = LOAD;
          busy_d  = 1'b0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = LOAD;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all of them sample the
  // pre-edge values of each other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      idx_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign idx   = idx_q;
  assign start = start_q;
  assign busy  = busy_q;
  assign err   = err_q;
endmodule

// File: rtl/f_loader.sv
// Streams a scalar plus a row-major matrix into shadow registers and commits
// the whole frame atomically before launching the controller.
module f_loader #(
  parameter int ROWS  = f_loader_pkg::ROWS,
  parameter int COLS  = f_loader_pkg::COLS,
  parameter int WIDTH = f_loader_pkg::WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_last,
  output logic [ROWS*COLS*WIDTH-1:0] x,
  output logic [WIDTH-1:0]           a,
  output logic                       start,
  input  logic                       done,
  output logic                       busy,
  output logic                       err
);
  localparam int FRAME_LEN = ROWS * COLS + 1;
  localparam int FLAT_W    = ROWS * COLS * WIDTH;
  localparam int CNT_W     = $clog2(FRAME_LEN);

  logic             accept, commit;
  logic [CNT_W-1:0] idx;

  logic [FLAT_W-1:0] shadow_x_q, shadow_x_d;
  logic [WIDTH-1:0]  shadow_a_q, shadow_a_d;
  logic [FLAT_W-1:0] x_q, x_d;
  logic [WIDTH-1:0]  a_q, a_d;

  f_loader_ctrl #(.FRAME_LEN(FRAME_LEN)) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_last (in_last),
    .done    (done),
    .in_ready(in_ready),
    .accept  (accept),
    .commit  (commit),
    .idx     (idx),
    .start   (start),
    .busy    (busy),
    .err     (err)
  );

  // The last element bypasses the shadow so the commit edge sees the full frame.
  always_comb begin
    shadow_x_d = shadow_x_q;
    shadow_a_d = shadow_a_q;
    if (accept) begin
      if (idx == '0) shadow_a_d = in_data;
      else           shadow_x_d[(int'(idx) - 1) * WIDTH +: WIDTH] = in_data;
    end
    x_d = commit ? shadow_x_d : x_q;
    a_d = commit ? shadow_a_d : a_q;
  end

  // NOTE: these wide registers are reset on purpose: the outputs must read as
  // zero after reset, so they cannot be left as uninitialised storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_x_q <= '0;
      shadow_a_q <= '0;
      x_q        <= '0;
      a_q        <= '0;
    end else begin
      shadow_x_q <= shadow_x_d;
      shadow_a_q <= shadow_a_d;
      x_q        <= x_d;
      a_q        <= a_d;
    end
  end

  assign x = x_q;
  assign a = a_q;
endmodule

// File: tb/tb_f_loader.sv
// Self-checking bench for f_loader against a frame-level reference model.
module tb_f_loader;
  localparam int W  = 64;
  localparam int NE = 30;
  localparam int N  = NE + 1;
  localparam int FW = NE * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last, start, done, busy, err;
  logic [W-1:0]  in_data, a;
  logic [FW-1:0] x;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] fw [N];
  logic [W-1:0] exp_a;
  logic [W-1:0] exp_e [NE];

  f_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .x(x), .a(a),
    .start(start), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [FW-1:0] exp_x();
    logic [FW-1:0] v;
    for (int k = 0; k < NE; k++) v[k*W +: W] = exp_e[k];
    return v;
  endfunction

  function automatic int first_diff(input logic [FW-1:0] got);
    for (int k = 0; k < NE; k++)
      if (got[k*W +: W] !== exp_e[k]) return k;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_commit();
    exp_a = fw[0];
    for (int k = 0; k < NE; k++) exp_e[k] = fw[k+1];
  endtask

  task automatic model_clear();
    exp_a = '0;
    for (int k = 0; k < NE; k++) exp_e[k] = '0;
  endtask

  task automatic fill_random();
    for (int w = 0; w < N; w++) fw[w] = {$urandom, $urandom};
  endtask

  task automatic fill_spec_frame();
    fw[0] = 64'd5;
    for (int k = 0; k < NE; k++) fw[k+1] = 64'(k + 100);
  endtask

  // Presents words 0..n_words-1; returns #1 after the edge accepting the last one.
  task automatic drive_frame(input int n_words, input int last_pos, input bit throttle);
    for (int w = 0; w < n_words; w++) begin
      if (throttle && w > 0) begin
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_last  = 1'($urandom);
        tick();
      end
      in_valid = 1'b1;
      in_data  = fw[w];
      in_last  = (w == last_pos);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_outputs_model(input string tag);
    vectors++;
    if (x !== exp_x() || a !== exp_a) begin
      miscompares++;
      $display("FAIL %s: a=%h want %h, x[%0d]=%h want %h", tag, a, exp_a,
               first_diff(x), x[first_diff(x)*W +: W], exp_e[first_diff(x)]);
    end
  endtask

  task automatic run_good_frame(input bit throttle, input int wait_cycles);
    drive_frame(N, N - 1, throttle);
    model_commit();
    vectors++;
    if ({start, busy, in_ready, err} !== 4'b1100) begin
      miscompares++;
      $display("FAIL launch: start/busy/in_ready/err=%b want 1100", {start, busy, in_ready, err});
    end
    check_outputs_model("commit");
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom};
    in_last  = 1'b1;
    tick();
    vectors++;
    if ({start, busy, in_ready} !== 3'b010) begin
      miscompares++;
      $display("FAIL start_pulse: start/busy/in_ready=%b want 010", {start, busy, in_ready});
    end
    repeat (wait_cycles) tick();
    vectors++;
    if ({busy, in_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL wait_state: busy/in_ready=%b want 10", {busy, in_ready});
    end
    check_outputs_model("hold_in_wait");
    in_valid = 1'b0;
    in_last  = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    vectors++;
    if ({in_ready, busy, start} !== 3'b100) begin
      miscompares++;
      $display("FAIL done_return: in_ready/busy/start=%b want 100", {in_ready, busy, start});
    end
    check_outputs_model("hold_after_done");
  endtask

  task automatic run_bad_frame(input int n_words, input int last_pos, input bit throttle);
    drive_frame(n_words, last_pos, throttle);
    vectors++;
    if ({err, in_ready, start, busy} !== 4'b1100) begin
      miscompares++;
      $display("FAIL err_pulse: err/in_ready/start/busy=%b want 1100", {err, in_ready, start, busy});
    end
    check_outputs_model("err_keeps_x");
    tick();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_width: err=%b want 0", err);
    end
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if (x !== '0 || a !== '0 || {start, busy, err, in_ready} !== 4'b0000) begin
      miscompares++;
      $display("FAIL %s: a=%h x_nonzero=%b start/busy/err/in_ready=%b want all 0",
               tag, a, |x, {start, busy, err, in_ready});
    end
  endtask

  task automatic release_and_poke_done(input string tag);
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ready: in_ready=%b want 1", tag, in_ready);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    vectors++;
    if ({start, busy, in_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL %s_done_ignored: start/busy/in_ready=%b want 001", tag, {start, busy, in_ready});
    end
    check_outputs_model({tag, "_zero"});
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; done = 1'b0;
    model_clear();
    repeat (3) tick();
    check_all_zero("reset_state");
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_spec_values(input string tag);
    vectors++;
    if (x[63:0] !== 64'd100 || x[1919:1856] !== 64'd129 || a !== 64'd5) begin
      miscompares++;
      $display("FAIL %s: x[63:0]=%0d x[1919:1856]=%0d a=%0d want 100 129 5",
               tag, x[63:0], x[1919:1856], a);
    end
  endtask

  task automatic test_back_to_back();
    fill_spec_frame();
    run_good_frame(1'b0, 2);
    test_spec_values("b2b_values");
  endtask

  task automatic test_throttled();
    fill_random();
    run_good_frame(1'b0, 1);
    fill_spec_frame();
    run_good_frame(1'b1, 1);
    test_spec_values("throttle_values");
  endtask

  task automatic test_short_frame();
    fill_random();
    run_bad_frame(13, 12, 1'b0);
    fill_random();
    run_bad_frame(N, -1, 1'b0);
    fill_random();
    run_good_frame(1'b0, 1);
  endtask

  task automatic test_done_handling();
    done = 1'b1;
    tick();
    done = 1'b0;
    vectors++;
    if ({in_ready, busy, start} !== 3'b100) begin
      miscompares++;
      $display("FAIL done_in_load: in_ready/busy/start=%b want 100", {in_ready, busy, start});
    end
    fill_random();
    run_good_frame(1'b0, 4);
  endtask

  task automatic test_reset_midframe();
    fill_random();
    drive_frame(17, -1, 1'b0);
    in_valid = 1'b1;
    in_data  = fw[17];
    rst      = 1'b1;
    #1;
    model_clear();
    check_all_zero("rst_midframe");
    release_and_poke_done("rst_midframe");
    fill_random();
    run_good_frame(1'b0, 1);
  endtask

  task automatic test_reset_wait();
    fill_random();
    drive_frame(N, N - 1, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    model_clear();
    check_all_zero("rst_wait");
    release_and_poke_done("rst_wait");
    fill_random();
    run_good_frame(1'b1, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      fill_random();
      case ($urandom_range(0, 2))
        0: run_good_frame(1'($urandom), $urandom_range(0, 5));
        1: begin
          int lp = $urandom_range(0, N - 2);
          run_bad_frame(lp + 1, lp, 1'($urandom));
        end
        default: run_bad_frame(N, -1, 1'($urandom));
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_throttled();
    test_short_frame();
    test_done_handling();
    test_reset_midframe();
    test_reset_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
